// File: rtl/mc_datapath_if.sv
// Memory bus between mc_datapath (master) and a memory/bus slave.
// A transfer completes on a rising clk edge where mem_req and mem_ready are
// both high; the master holds addr/we/wdata stable until then.
interface mc_datapath_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Supports add/sub/and/or/slt (R-type), addi, lw, sw and beq; anything else
// retires as a NOP. Defining MC_DATAPATH_JMP_EN adds the j instruction.
// All outputs, including the memory request, come straight from flops so the
// request drops asynchronously with rst_n.
module mc_datapath #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_datapath_if.master   mem,
    output logic [XLEN-1:0] pc,
    output logic [2:0]      state,
    output logic            retire
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // What EXEC decides to do with the current instruction.
    typedef enum logic [2:0] {
        K_NOP = 3'd0,
        K_WB  = 3'd1,
        K_MEM = 3'd2,
        K_BEQ = 3'd3,
        K_JMP = 3'd4
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};

    // Architectural and micro-architectural state
    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] aluout_q;
    logic [XLEN-1:0] mdr_q;
    logic [XLEN-1:0] rf_q [0:31];
    logic            retire_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

    // Instruction fields
    logic [5:0]      op_s;
    logic [4:0]      rs_s;
    logic [4:0]      rt_s;
    logic [4:0]      rd_s;
    logic [5:0]      funct_s;
    logic [XLEN-1:0] imm_sext_s;
    logic [XLEN-1:0] rs_val_s;
    logic [XLEN-1:0] rt_val_s;
    logic [XLEN-1:0] jtarget_s;
    logic [4:0]      wb_idx_s;
    logic [XLEN-1:0] wb_data_s;
    logic [XLEN-1:0] alu_s;
    kind_t           kind_s;
    logic            unused_ir_s;

    assign op_s       = ir_q[31:26];
    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign funct_s    = ir_q[5:0];
    assign imm_sext_s = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    // shamt is not used by any supported instruction
    assign unused_ir_s = ^ir_q[10:6];

    // r0 is hard-wired to zero on the read side as well as never written
    assign rs_val_s = (rs_s == 5'd0) ? ZERO_X : rf_q[rs_s];
    assign rt_val_s = (rt_s == 5'd0) ? ZERO_X : rf_q[rt_s];

    // Jump target keeps the upper PC bits of the already-incremented PC
    assign jtarget_s = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};

    // R-type writes rd; addi and lw write rt; lw writes the loaded word
    assign wb_idx_s  = (op_s == OP_RTYPE) ? rd_s : rt_s;
    assign wb_data_s = (op_s == OP_LW) ? mdr_q : aluout_q;

    // EXEC-stage ALU and instruction classification
    always_comb begin
        alu_s  = ZERO_X;
        kind_s = K_NOP;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD: begin
                        alu_s  = a_q + b_q;
                        kind_s = K_WB;
                    end
                    FN_SUB: begin
                        alu_s  = a_q - b_q;
                        kind_s = K_WB;
                    end
                    FN_AND: begin
                        alu_s  = a_q & b_q;
                        kind_s = K_WB;
                    end
                    FN_OR: begin
                        alu_s  = a_q | b_q;
                        kind_s = K_WB;
                    end
                    FN_SLT: begin
                        if ($signed(a_q) < $signed(b_q)) begin
                            alu_s = ONE_X;
                        end else begin
                            alu_s = ZERO_X;
                        end
                        kind_s = K_WB;
                    end
                    default: begin
                        alu_s  = ZERO_X;
                        kind_s = K_NOP;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_s  = a_q + imm_sext_s;
                kind_s = K_WB;
            end
            OP_LW, OP_SW: begin
                alu_s  = a_q + imm_sext_s;
                kind_s = K_MEM;
            end
            OP_BEQ: begin
                alu_s  = ZERO_X;
                kind_s = K_BEQ;
            end
`ifdef MC_DATAPATH_JMP_EN
            OP_J: begin
                alu_s  = ZERO_X;
                kind_s = K_JMP;
            end
`else
            OP_J: begin
                alu_s  = ZERO_X;
                kind_s = K_NOP;
            end
`endif
            default: begin
                alu_s  = ZERO_X;
                kind_s = K_NOP;
            end
        endcase
    end

    // Main FSM: sequences the datapath, owns every register and all outputs.
    // Each transition back into FETCH raises the fetch request right away so
    // the first FETCH cycle already drives the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            a_q         <= ZERO_X;
            b_q         <= ZERO_X;
            aluout_q    <= ZERO_X;
            mdr_q       <= ZERO_X;
            retire_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ZERO_X;
            mem_wdata_q <= ZERO_X;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= ZERO_X;
            end
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!mem_req_q) begin
                        // first cycle out of reset: issue the fetch
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem.mem_ready) begin
                        ir_q      <= mem.mem_rdata[31:0];
                        pc_q      <= pc_q + PC_STEP;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q      <= rs_val_s;
                    b_q      <= rt_val_s;
                    aluout_q <= pc_q + {imm_sext_s[XLEN-3:0], 2'b00};
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    case (kind_s)
                        K_WB: begin
                            aluout_q <= alu_s;
                            state_q  <= S_WB;
                        end
                        K_MEM: begin
                            aluout_q    <= alu_s;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op_s == OP_SW);
                            mem_addr_q  <= alu_s;
                            mem_wdata_q <= b_q;
                            state_q     <= S_MEM;
                        end
                        K_BEQ: begin
                            retire_q   <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            state_q    <= S_FETCH;
                            if (a_q == b_q) begin
                                pc_q       <= aluout_q;
                                mem_addr_q <= aluout_q;
                            end else begin
                                mem_addr_q <= pc_q;
                            end
                        end
                        K_JMP: begin
                            retire_q   <= 1'b1;
                            pc_q       <= jtarget_s;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= jtarget_s;
                            state_q    <= S_FETCH;
                        end
                        default: begin
                            retire_q   <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_q;
                            state_q    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        if (mem_we_q) begin
                            // store done: straight back to fetch
                            retire_q   <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_q;
                            state_q    <= S_FETCH;
                        end else begin
                            mdr_q     <= mem.mem_rdata;
                            mem_req_q <= 1'b0;
                            state_q   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx_s != 5'd0) begin
                        rf_q[wb_idx_s] <= wb_data_s;
                    end
                    retire_q   <= 1'b1;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                    state_q    <= S_FETCH;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    state_q   <= S_FETCH;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign pc            = pc_q;
    assign state         = state_q;
    assign retire        = retire_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath (XLEN=64): a small memory model answers the
// bus with a programmable wait count in MEM, programs are hand-assembled and
// every expected value is worked out by hand below.
module tb_mc_datapath;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] pc;
    logic [2:0]      state;
    logic            retire;

    mc_datapath_if #(.XLEN(XLEN)) bus ();

    mc_datapath #(.XLEN(XLEN), .RESET_PC(64'd0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem    (bus.master),
        .pc     (pc),
        .state  (state),
        .retire (retire)
    );

    logic [63:0] mem_a [0:255];
    int          mem_lat;
    int          wait_cnt;
    int          wr_cnt;
    int          hold_cnt;
    int          lat_sel;
    int          n_checks;
    int          n_pass;
    int          lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ready after mem_lat wait cycles in MEM, zero-wait otherwise
    always @(negedge clk) begin
        lat_sel = (state == 3'd3) ? mem_lat : 0;
        bus.mem_ready = bus.mem_req && (wait_cnt >= lat_sel);
        bus.mem_rdata = mem_a[bus.mem_addr[9:2]];
        if (bus.mem_req && !bus.mem_we && bus.mem_addr == 64'h18) hold_cnt++;
    end

    // Completes transfers on the active edge and performs stores
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ready) begin
            if (bus.mem_we) begin
                mem_a[bus.mem_addr[9:2]] = bus.mem_wdata;
                wr_cnt++;
            end
            wait_cnt = 0;
        end else if (bus.mem_req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_a[i] = 64'd0;
    endtask

    // Holds reset, then releases it on a negedge and moves to the first FETCH sample
    task automatic reset_start();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts negedges from the current FETCH sample until retire is seen (bounded)
    task automatic wait_retire(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 40);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mem_lat  = 0;
        wait_cnt = 0;
        wr_cnt   = 0;
        hold_cnt = 0;
        rst_n    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 64'd0;

        // ---------------- Run A: addi / lw with waits / sub / slt / beq
        clear_mem();
        mem_a[0] = {32'd0, enc_i(6'h08, 5'd0, 5'd1, 16'd5)};      // addi r1,r0,5
        mem_a[1] = {32'd0, enc_i(6'h08, 5'd0, 5'd1, 16'h10)};     // addi r1,r0,0x10
        mem_a[2] = {32'd0, enc_i(6'h23, 5'd1, 5'd2, 16'd8)};      // lw r2,8(r1)
        mem_a[3] = {32'd0, enc_i(6'h08, 5'd0, 5'd1, 16'd1)};      // addi r1,r0,1
        mem_a[4] = {32'd0, enc_r(5'd0, 5'd1, 5'd3, 6'h22)};       // sub r3,r0,r1
        mem_a[5] = {32'd0, enc_i(6'h04, 5'd0, 5'd0, 16'd2)};      // beq r0,r0,+2 -> 0x20
        mem_a[6] = 64'hCAFE;                                      // data word at 0x18
        mem_a[7] = {32'd0, enc_r(5'd3, 5'd0, 5'd4, 6'h2A)};       // slt r4,r3,r0
        mem_a[8] = {32'd0, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE)};   // beq r1,r1,-2 -> 0x1C

        repeat (2) @(negedge clk);
        #2;
        check_val("rst_pc", pc, 64'd0);
        check_val("rst_state", {61'd0, state}, 64'd0);
        check_val("rst_req", {63'd0, bus.mem_req}, 64'd0);
        check_val("rst_we", {63'd0, bus.mem_we}, 64'd0);
        check_val("rst_retire", {63'd0, retire}, 64'd0);

        reset_start();
        check_val("first_fetch_req", {63'd0, bus.mem_req}, 64'd1);
        check_val("first_fetch_addr", bus.mem_addr, 64'd0);

        wait_retire(lat);
        check_val("addi_lat", lat, 64'd4);
        check_val("addi_pc", pc, 64'd4);
        check_val("addi_r1", dut.rf_q[1], 64'd5);

        wait_retire(lat);
        check_val("addi2_r1", dut.rf_q[1], 64'h10);

        mem_lat  = 3;
        hold_cnt = 0;
        wait_retire(lat);
        check_val("lw_lat", lat, 64'd8);
        check_val("lw_addr_hold", hold_cnt, 64'd4);
        check_val("lw_r2", dut.rf_q[2], 64'hCAFE);
        mem_lat = 0;

        wait_retire(lat);
        check_val("addi3_r1", dut.rf_q[1], 64'd1);

        wait_retire(lat);
        check_val("sub_lat", lat, 64'd4);
        check_val("sub_r3", dut.rf_q[3], 64'hFFFF_FFFF_FFFF_FFFF);

        wait_retire(lat);
        check_val("beq_fwd_lat", lat, 64'd3);
        check_val("beq_fwd_pc", pc, 64'h20);

        wait_retire(lat);
        check_val("beq_back_lat", lat, 64'd3);
        check_val("beq_back_pc", pc, 64'h1C);
        check_val("beq_no_write", wr_cnt, 64'd0);
        check_val("beq_r3_kept", dut.rf_q[3], 64'hFFFF_FFFF_FFFF_FFFF);

        wait_retire(lat);
        check_val("slt_neg_r4", dut.rf_q[4], 64'd1);

        // ---------------- Run B: remaining ALU ops, sw, r0, illegal encodings
        clear_mem();
        mem_a[0]  = {32'd0, enc_i(6'h08, 5'd0, 5'd5, 16'd7)};     // addi r5,r0,7
        mem_a[1]  = {32'd0, enc_i(6'h08, 5'd0, 5'd6, 16'hFFFD)};  // addi r6,r0,-3
        mem_a[2]  = {32'd0, enc_r(5'd5, 5'd6, 5'd7, 6'h20)};      // add r7,r5,r6
        mem_a[3]  = {32'd0, enc_r(5'd5, 5'd6, 5'd8, 6'h24)};      // and r8,r5,r6
        mem_a[4]  = {32'd0, enc_r(5'd5, 5'd6, 5'd9, 6'h25)};      // or r9,r5,r6
        mem_a[5]  = {32'd0, enc_r(5'd6, 5'd5, 5'd11, 6'h2A)};     // slt r11,r6,r5
        mem_a[6]  = {32'd0, enc_i(6'h2B, 5'd0, 5'd7, 16'h40)};    // sw r7,0x40(r0)
        mem_a[7]  = {32'd0, enc_r(5'd5, 5'd6, 5'd7, 6'h2A)};      // slt r7,r5,r6
        mem_a[8]  = {32'd0, enc_i(6'h08, 5'd0, 5'd0, 16'd9)};     // addi r0,r0,9
        mem_a[9]  = {32'd0, enc_r(5'd0, 5'd5, 5'd12, 6'h20)};     // add r12,r0,r5
        mem_a[10] = 64'h0000_0000_FC00_0000;                       // unknown opcode
        mem_a[11] = {32'd0, enc_r(5'd5, 5'd6, 5'd13, 6'h3F)};     // unknown funct
        wr_cnt = 0;
        reset_start();
        check_val("rst_clears_r1", dut.rf_q[1], 64'd0);

        wait_retire(lat);
        wait_retire(lat);
        check_val("addi_neg_r6", dut.rf_q[6], 64'hFFFF_FFFF_FFFF_FFFD);
        wait_retire(lat);
        check_val("add_wrap_r7", dut.rf_q[7], 64'd4);
        wait_retire(lat);
        check_val("and_r8", dut.rf_q[8], 64'd5);
        wait_retire(lat);
        check_val("or_r9", dut.rf_q[9], 64'hFFFF_FFFF_FFFF_FFFF);
        wait_retire(lat);
        check_val("slt_signed_r11", dut.rf_q[11], 64'd1);
        wait_retire(lat);
        check_val("sw_lat", lat, 64'd4);
        check_val("sw_data", mem_a[16], 64'd4);
        check_val("sw_count", wr_cnt, 64'd1);
        wait_retire(lat);
        check_val("slt_false_r7", dut.rf_q[7], 64'd0);
        wait_retire(lat);
        wait_retire(lat);
        check_val("r0_ignored", dut.rf_q[12], 64'd7);
        wait_retire(lat);
        check_val("bad_op_lat", lat, 64'd3);
        check_val("bad_op_pc", pc, 64'h2C);
        wait_retire(lat);
        check_val("bad_fn_lat", lat, 64'd3);
        check_val("bad_fn_r13", dut.rf_q[13], 64'd0);
        check_val("nop_no_write", wr_cnt, 64'd1);

        // ---------------- Run C: j 0x40 at pc 0
        clear_mem();
        mem_a[0] = 64'h0000_0000_0800_0040;
        reset_start();
        wait_retire(lat);
        check_val("j_lat", lat, 64'd3);
`ifdef MC_DATAPATH_JMP_EN
        check_val("j_pc", pc, 64'h100);
`else
        check_val("j_pc", pc, 64'd4);
`endif

        // ---------------- Run D: reset during a stalled sw
        clear_mem();
        mem_a[0]  = {32'd0, enc_i(6'h2B, 5'd0, 5'd0, 16'h40)};    // sw r0,0x40(r0)
        mem_a[16] = 64'h1234;
        mem_lat   = 10;
        wr_cnt    = 0;
        reset_start();
        for (int i = 0; i < 20 && state != 3'd3; i++) @(negedge clk);
        check_val("sw_in_mem", {61'd0, state}, 64'd3);
        check_val("sw_req_before", {63'd0, bus.mem_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_req_drop", {63'd0, bus.mem_req}, 64'd0);
        check_val("abort_state", {61'd0, state}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        mem_lat = 0;
        check_val("abort_no_write", wr_cnt, 64'd0);
        check_val("abort_mem_kept", mem_a[16], 64'h1234);
        @(posedge clk);
        #1;
        check_val("refetch_req", {63'd0, bus.mem_req}, 64'd1);
        check_val("refetch_addr", bus.mem_addr, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath and register width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_req, output, 1 bit: memory transfer request.
REQ-006 The block SHALL have port mem_we, output, 1 bit: the request is a write.
REQ-007 The block SHALL have port mem_addr, output, XLEN bits: byte address of the transfer.
REQ-008 The block SHALL have port mem_wdata, output, XLEN bits: write data.
REQ-009 The block SHALL have port mem_rdata, input, XLEN bits: read data, valid when mem_ready=1.
REQ-010 The block SHALL have port mem_ready, input, 1 bit: the transfer completes this cycle.
REQ-011 The block SHALL have port pc, output, XLEN bits: the current program counter.
REQ-012 The block SHALL have port state, output, 3 bits: FSM state encoding, as listed in REQ-016.
REQ-013 The block SHALL have port retire, output, 1 bit: a one-cycle pulse when an instruction completes.

Function
REQ-014 Memory handshake: a transfer SHALL complete on each rising edge where mem_req=1 and mem_ready=1; mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0; mem_ready SHALL be ignored while mem_req=0.
REQ-015 Register file: 32 entries of XLEN bits; r0 SHALL read as zero and SHALL ignore writes.
REQ-016 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3 and WB=4.
REQ-017 FETCH: the block SHALL drive mem_req=1, mem_we=0 and mem_addr=pc; on completion it SHALL set IR=mem_rdata[31:0] and pc=pc+4, then move to DECODE.
REQ-018 DECODE: the block SHALL latch A=reg[rs] and B=reg[rt], latch ALUOut=pc+(sext(imm16)<<2), then move to EXEC.
REQ-019 EXEC, R-type (op=0; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt): the block SHALL set ALUOut=A op B, then move to WB.
REQ-020 EXEC, addi (0x08): ALUOut SHALL be A+sext(imm16), then move to WB.
REQ-021 EXEC, lw (0x23) or sw (0x2B): ALUOut SHALL be A+sext(imm16), then move to MEM.
REQ-022 EXEC, beq (0x04): if A==B the block SHALL set pc=ALUOut; it SHALL then retire and move to FETCH.
REQ-023 MEM, lw: mem_req=1, mem_we=0, mem_addr=ALUOut; on completion MDR=mem_rdata, then move to WB.
REQ-024 MEM, sw: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; on completion the block SHALL retire and move to FETCH.
REQ-025 WB: the block SHALL write R-type results to rd, addi results to rt and lw results (MDR) to rt, then retire and move to FETCH.
REQ-026 An unrecognised opcode or funct in EXEC SHALL be treated as a NOP: retire, no register or memory write, move to FETCH.
REQ-027 Arithmetic SHALL wrap modulo 2^XLEN with no overflow trap; slt SHALL be a signed compare producing 1 or 0.
REQ-028 Zero-wait latency SHALL be: R-type/addi 4 cycles, lw 5, sw 4, beq 3.
REQ-029 mem_req SHALL be 1 only in FETCH and MEM.
REQ-030 retire SHALL assert exactly once per instruction, on the cycle the FSM leaves its final state.

Reset
REQ-031 While rst_n=0 the block SHALL immediately hold pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, and IR, A, B, ALUOut, MDR and all registers at 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer; mem_req SHALL drop asynchronously.
REQ-033 After rst_n rises, the block SHALL issue the first fetch from RESET_PC on the next clock edge.

Configuration
REQ-034 With macro MC_DATAPATH_JMP_EN defined, j (0x02) SHALL execute in EXEC as pc={pc[XLEN-1:28], addr26, 2'b00}, retire and move to FETCH, taking 3 cycles.
REQ-035 Without MC_DATAPATH_JMP_EN, opcode 0x02 SHALL be handled per REQ-026.

Verification
REQ-036 Reset, then addi r1,r0,5 with mem_ready tied 1 -> r1=5, retire on cycle 4, pc=4.
REQ-037 lw r2,8(r1) with r1=0x10, memory word 0x18=0xCAFE and mem_ready delayed 3 cycles in MEM -> mem_addr held at 0x18 for 4 cycles, r2=0xCAFE, latency 8 cycles.
REQ-038 beq r1,r1,-2 at pc=0x20 -> pc=0x1C after 3 cycles, with no register or memory write.
REQ-039 sub r3,r0,r1 with r1=1 and XLEN=64 -> r3=0xFFFF_FFFF_FFFF_FFFF; slt r4,r3,r0 -> r4=1.
REQ-040 rst_n pulsed low during MEM of sw -> mem_req drops immediately, no write completes, and the next fetch is from RESET_PC.
REQ-041 j 0x40 at pc=0 -> with MC_DATAPATH_JMP_EN, pc=0x100 after 3 cycles; without it, pc=4 and a NOP retires.
